// File: rtl/req_ack_pkg.sv
// Shared types and helpers for the req/ack responder: FSM state encoding,
// default latency/queue parameters and the latency clamp.
package req_ack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int unsigned DEF_MIN_LAT = 1;
  localparam int unsigned DEF_MAX_LAT = 3;
  localparam int unsigned DEF_DEPTH   = 4;

  function automatic int unsigned clamp_lat(input int unsigned lat,
                                            input int unsigned min_lat,
                                            input int unsigned max_lat);
    if (lat < min_lat) return min_lat;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/ack_lat_counter.sv
// Service latency down-counter: loaded with L-1 at service start and
// decremented toward zero while a request is in service.
module ack_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         cnt_zero,
  output logic         cnt_one
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == W'(1));

endmodule

// File: rtl/req_ack_responder.sv
// Responder end of a req/ack handshake: one ack pulse per accepted request,
// L cycles after its service starts, with a saturating queue behind it.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned MIN_LAT = DEF_MIN_LAT,
  parameter int unsigned MAX_LAT = DEF_MAX_LAT,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1),
  parameter int unsigned PEND_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [LAT_W-1:0]  lat_cfg,
  output logic              ack,
  output logic              valid,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [PEND_W-1:0] pending_q, pending_d, pend_cnt;
  logic              overflow_q, overflow_d;
  logic [LAT_W-1:0]  lat;
  logic              load, complete, valid_raw;
  logic              cnt_zero, cnt_one;

  assign lat = LAT_W'(clamp_lat(32'(lat_cfg), MIN_LAT, MAX_LAT));

  ack_lat_counter #(.W(LAT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .en       (state_q == SERVE),
    .load_val (lat - LAT_W'(1)),
    .cnt_zero (cnt_zero),
    .cnt_one  (cnt_one)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    pend_cnt   = pending_q;
    load       = 1'b0;
    complete   = (state_q == SERVE) && cnt_zero;

    // Requests arriving during service (completion cycle included) are queued first.
    if (state_q == SERVE && req) begin
      if (pending_q == PEND_W'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        pend_cnt = pending_q + PEND_W'(1);
      end
    end
    pending_d = pend_cnt;

    if (state_q == IDLE) begin
      if (req) begin
        load    = 1'b1;
        state_d = SERVE;
      end
    end else if (complete) begin
      if (pend_cnt != '0) begin
        load      = 1'b1;
        pending_d = pend_cnt - PEND_W'(1);
      end else begin
        state_d = IDLE;
      end
    end

    // The ack cycle is the one where cnt reaches 0, so valid leads it by one.
    valid_raw = (load && lat == LAT_W'(1)) || (state_q == SERVE && cnt_one);
    ack_d     = valid_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = rst_n & valid_raw;
  assign ack      = ack_q;
  assign busy     = (state_q == SERVE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench: directed scenarios plus randomized req/lat_cfg traffic
// compared every cycle against a time-stamped service/queue model.
module tb_req_ack_responder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [1:0] lat_cfg = 2'd0;
  logic       ack, valid, busy, overflow;
  logic [2:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  req_ack_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lat_cfg  (lat_cfg),
    .ack      (ack),
    .valid    (valid),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int clamp(input int l);
    if (l < 1) return 1;
    if (l > 3) return 3;
    return l;
  endfunction

  // Model: one request in service with an absolute ack cycle, plus a count of waiters.
  int cyc        = 0;
  bit m_busy     = 1'b0;
  int m_ack_time = 0;
  int m_queued   = 0;
  bit m_ovf      = 1'b0;
  bit unq_open   = 1'b0;
  int unq_start  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_queued = 0;
      m_ovf    = 1'b0;
      unq_open = 1'b0;
      check("rst_ack", ack, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pending", pending, 0);
      check("rst_overflow", overflow, 0);
    end else begin
      check("ack", ack, int'(m_busy && m_ack_time == cyc));
      check("busy", busy, int'(m_busy));
      check("pending", pending, m_queued);
      check("overflow", overflow, int'(m_ovf));

      // A request that finds the responder idle must see its ack 1..3 cycles later.
      if (unq_open) begin
        if (ack) begin
          check("unqueued_latency_in_range",
                int'(cyc - unq_start >= 1 && cyc - unq_start <= 3), 1);
          unq_open = 1'b0;
        end else if (cyc - unq_start > 3) begin
          check("unqueued_ack_timeout", 0, 1);
          unq_open = 1'b0;
        end
      end
      if (req && !busy) begin
        unq_open  = 1'b1;
        unq_start = cyc;
      end

      if (!m_busy) begin
        if (req) begin
          m_busy     = 1'b1;
          m_ack_time = cyc + clamp(int'(lat_cfg));
        end
      end else begin
        if (req) begin
          if (m_queued < DEPTH) m_queued++;
          else m_ovf = 1'b1;
        end
        if (cyc == m_ack_time) begin
          if (m_queued > 0) begin
            m_queued--;
            m_ack_time = cyc + clamp(int'(lat_cfg));
          end else begin
            m_busy = 1'b0;
          end
        end
      end
      check("valid", valid, int'(m_busy && m_ack_time == cyc + 1));
    end
    cyc++;
  end

  assert property (@(posedge clk) disable iff (!rst_n) valid |=> ack);
  assert property (@(posedge clk) disable iff (!rst_n) $rose(valid) |=> ack);
  assert property (@(posedge clk) disable iff (!rst_n) ack |-> $past(valid));

  task automatic set_in(input bit r, input int l);
    req     = r;
    lat_cfg = 2'(l);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ack_at[8];
  int n_ack;
  int peak;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("reset_busy", busy, 0);
    check("reset_pending", pending, 0);

    // L=2: valid one cycle ahead, single ack, busy spans start+1..ack.
    set_in(1, 2);
    tick();
    set_in(0, 0);
    check("l2_busy_t1", busy, 1);
    check("l2_valid_t1", valid, 1);
    check("l2_ack_t1", ack, 0);
    tick();
    check("l2_ack_t2", ack, 1);
    check("l2_busy_t2", busy, 1);
    check("l2_valid_t2", valid, 0);
    tick();
    check("l2_ack_t3", ack, 0);
    check("l2_busy_t3", busy, 0);

    // L=1 and clamped L=0: combinational valid in the request cycle.
    for (int l = 1; l >= 0; l--) begin
      set_in(1, l);
      check("l01_valid_t0", valid, 1);
      tick();
      set_in(0, 0);
      check("l01_ack_t1", ack, 1);
      tick();
      check("l01_ack_t2", ack, 0);
      check("l01_busy_t2", busy, 0);
    end

    // L=3 (top of range).
    set_in(1, 3);
    check("l3_valid_t0", valid, 0);
    tick();
    set_in(0, 3);
    check("l3_valid_t1", valid, 0);
    tick();
    check("l3_valid_t2", valid, 1);
    check("l3_ack_t2", ack, 0);
    tick();
    check("l3_ack_t3", ack, 1);
    tick();

    // Three back-to-back requests at L=3: acks at +3, +6, +9.
    n_ack = 0;
    peak  = 0;
    for (int k = 0; k < 14; k++) begin
      set_in(k < 3, 3);
      tick();
      if (ack && n_ack < 8) begin
        ack_at[n_ack] = k + 1;
        n_ack++;
      end
      if (int'(pending) > peak) peak = int'(pending);
    end
    check("b2b_ack_count", n_ack, 3);
    check("b2b_ack0", ack_at[0], 3);
    check("b2b_ack1", ack_at[1], 6);
    check("b2b_ack2", ack_at[2], 9);
    check("b2b_peak_pending", peak, 2);
    check("b2b_final_pending", pending, 0);
    check("b2b_final_busy", busy, 0);

    // Eight held requests at L=3: one dropped at the second completion, seven acks.
    n_ack = 0;
    peak  = 0;
    for (int k = 0; k < 30; k++) begin
      set_in(k < 8, 3);
      tick();
      if (ack) n_ack++;
      if (int'(pending) > peak) peak = int'(pending);
    end
    check("ovf_peak_pending", peak, DEPTH);
    check("ovf_ack_count", n_ack, 7);
    check("ovf_sticky", overflow, 1);
    check("ovf_idle_after", busy, 0);

    // Reset mid-service aborts everything.
    set_in(1, 3);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_ack", ack, 0);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pending", pending, 0);
    check("abort_overflow", overflow, 0);
    set_in(0, 3);
    tick();
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack) n_ack++;
    end
    check("abort_no_ack", n_ack, 0);

    // Random traffic with alternating light/heavy phases and rare resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        rst_n = 1'b0;
        set_in(0, 0);
        tick();
        rst_n = 1'b1;
      end else begin
        set_in($urandom_range(99, 0) < (((i / 250) % 2) != 0 ? 75 : 30),
               int'($urandom_range(3, 0)));
        tick();
      end
    end

    set_in(0, 0);
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
